axi_req_arbiter: RTL and testbench
==================================

// Module: axi_req_arbiter
// PURPOSE
//  Shares the single 128-bit line-fill/writeback port of axi_m (4-beat x 32-bit burst master) between
//  the I-cache and D-cache requesters of rvcore. Selects one requester and issues a one-cycle
//  request pulse to axi_m. Waits for the matching rd/wr completion pulse, then returns data and a
//  one-cycle done pulse to the granted requester. Only one transaction is outstanding at a time.
// PARAMETERS
//  ADDR_W     32   request address width
//  DATA_W     128  line width (request and response data)
//  PRIO_MODE  0    0 = round-robin; 1 = fixed priority, D-cache always wins ties
//  TIMEOUT    0    WAIT-state watchdog limit in cycles; 0 disables the watchdog
// PORTS
//  M_AXI_ACLK       in   1       clock
//  M_AXI_ARESETN    in   1       asynchronous active-low reset
//  ic_req_i         in   1       I-cache request; level, held until ic_done_o
//  ic_rw_i          in   1       1 = read (fill), 0 = write; stable while ic_req_i=1
//  ic_addr_i        in   ADDR_W  line address; stable while ic_req_i=1
//  ic_data_i        in   DATA_W  write data; stable while ic_req_i=1
//  ic_data_o        out  DATA_W  read data for I-cache
//  ic_done_o        out  1       one-cycle completion pulse to I-cache
//  dc_req_i/dc_rw_i/dc_addr_i/dc_data_i/dc_data_o/dc_done_o   same as ic_*, for the D-cache
//  bus_valid_req_o  out  1       to axi_m Rvcore_valid_req_i; one-cycle pulse
//  bus_rw_o         out  1       to axi_m Rvcore_rw_i
//  bus_addr_o       out  ADDR_W  to axi_m Rvcore_addr_i
//  bus_data_o       out  DATA_W  to axi_m Rvcore_data_i
//  bus_data_i       in   DATA_W  from axi_m axi_data_o
//  bus_rd_over_i    in   1       from axi_m axi_rd_over_o
//  bus_wr_over_i    in   1       from axi_m axi_wr_over_o
//  grant_o          out  2       {dc,ic} one-hot owner; 00 when idle
//  busy_o           out  1       1 in every state except IDLE
//  timeout_o        out  1       sticky watchdog error flag
// BEHAVIOUR
//  Reset (async, ARESETN=0): state=IDLE; all outputs 0; last_grant=IC; watchdog counter 0.
//   Reset mid-transaction abandons the transaction; axi_m shares the same reset net.
//  All outputs are registered.
//  FSM: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//  IDLE: if any req_i=1, pick the winner, capture its rw/addr/data into bus_*_o, set grant_o, go ISSUE.
//   Arbitration with a single requester: that requester wins.
//   Arbitration with both requesting, PRIO_MODE=0: grant the one != last_grant.
//   Arbitration with both requesting, PRIO_MODE=1: grant D-cache.
//  ISSUE: exactly one cycle; bus_valid_req_o=1; last_grant<=winner; go WAIT.
//  WAIT: bus_valid_req_o=0; bus_addr_o/bus_rw_o/bus_data_o held stable.
//   Read (bus_rw_o=1): exit on bus_rd_over_i=1. Write: exit on bus_wr_over_i=1.
//   A non-matching over pulse is ignored. Over pulses seen outside WAIT are ignored.
//   On exit: for a read, latch bus_data_i into the granted requester's data_o; go DONE.
//  DONE: the granted requester's done_o=1 for exactly one cycle; next state IDLE.
//   grant_o clears on entry to IDLE.
//  Requester contract: drop req_i on the edge that samples done_o=1, so req_i is already 0 in the
//   following IDLE cycle. A re-asserted request in that cycle is a legal new request.
//  Latency: req_i edge to bus_valid_req_o = 2 cycles; over_i to done_o = 1 cycle.
//  data_o updates only on read completion for that requester. Otherwise it holds its last value;
//   writes never alter it.
//  Requests arriving while busy_o=1 wait; no request is dropped. Under round-robin, neither
//   requester waits more than one transaction.
//  Watchdog: the counter clears on WAIT entry and increments each WAIT cycle.
//   If TIMEOUT!=0 and count==TIMEOUT, timeout_o<=1 (sticky until reset); the FSM keeps waiting.
//   The counter saturates.
// TESTING
//  1. IC read only, addr=0x100; axi_m returns 0x44..33..22..11 -> one bus_valid_req_o pulse 2 cycles
//     after req; ic_done_o 1 cycle after rd_over; ic_data_o=128'h44..11; dc_done_o never set.
//  2. DC write addr=0x200, data=128'hA5.. -> bus_rw_o=0, bus_data_o=data; done on wr_over only.
//     A stray rd_over during WAIT is ignored. dc_data_o unchanged.
//  3. IC and DC request in the same cycle, PRIO_MODE=0, from reset -> DC served first, then IC.
//     Repeat both requesting -> order alternates DC, IC, DC, IC.
//  4. PRIO_MODE=1, DC requests continuously while IC is pending -> DC always granted.
//  5. TIMEOUT=8 and over is withheld -> timeout_o rises after 8 WAIT cycles and stays high.
//     A late over still produces done_o.
//  6. Assert ARESETN=0 during WAIT -> all outputs 0 immediately. After release: IDLE, busy_o=0,
//     and a new request issues normally.

Source files
------------

// File: rtl/axi_req_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter in front of the single-outstanding
// axi_m line port: pick, issue a one-cycle request, wait for the matching over pulse, return.
module axi_req_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned TIMEOUT   = 0
) (
  input  logic              M_AXI_ACLK,
  input  logic              M_AXI_ARESETN,
  input  logic              ic_req_i,
  input  logic              ic_rw_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  input  logic [DATA_W-1:0] ic_data_i,
  output logic [DATA_W-1:0] ic_data_o,
  output logic              ic_done_o,
  input  logic              dc_req_i,
  input  logic              dc_rw_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [DATA_W-1:0] dc_data_i,
  output logic [DATA_W-1:0] dc_data_o,
  output logic              dc_done_o,
  output logic              bus_valid_req_o,
  output logic              bus_rw_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_data_o,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              bus_rd_over_i,
  input  logic              bus_wr_over_i,
  output logic [1:0]        grant_o,
  output logic              busy_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state;
  logic        last_dc;
  logic [31:0] wd_cnt;
  logic        pick_dc;
  logic        over_hit;

  // Ties go to D-cache in fixed mode, otherwise to whoever was not served last.
  assign pick_dc  = dc_req_i && (!ic_req_i || (PRIO_MODE != 0) || !last_dc);
  assign over_hit = bus_rw_o ? bus_rd_over_i : bus_wr_over_i;

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state           <= IDLE;
      last_dc         <= 1'b0;
      wd_cnt          <= '0;
      ic_data_o       <= '0;
      ic_done_o       <= 1'b0;
      dc_data_o       <= '0;
      dc_done_o       <= 1'b0;
      bus_valid_req_o <= 1'b0;
      bus_rw_o        <= 1'b0;
      bus_addr_o      <= '0;
      bus_data_o      <= '0;
      grant_o         <= 2'b00;
      busy_o          <= 1'b0;
      timeout_o       <= 1'b0;
    end else begin
      bus_valid_req_o <= 1'b0;
      ic_done_o       <= 1'b0;
      dc_done_o       <= 1'b0;
      case (state)
        IDLE: begin
          if (ic_req_i || dc_req_i) begin
            grant_o    <= pick_dc ? 2'b10 : 2'b01;
            bus_rw_o   <= pick_dc ? dc_rw_i   : ic_rw_i;
            bus_addr_o <= pick_dc ? dc_addr_i : ic_addr_i;
            bus_data_o <= pick_dc ? dc_data_i : ic_data_i;
            busy_o     <= 1'b1;
            state      <= ISSUE;
          end
        end
        // Request pulse is launched from ISSUE, so it is seen two cycles after req_i.
        ISSUE: begin
          bus_valid_req_o <= 1'b1;
          last_dc         <= grant_o[1];
          wd_cnt          <= '0;
          state           <= WAIT;
        end
        WAIT: begin
          if (wd_cnt != '1) wd_cnt <= wd_cnt + 32'd1;
          if (TIMEOUT != 0 && wd_cnt == TIMEOUT) timeout_o <= 1'b1;
          if (over_hit) begin
            if (bus_rw_o && grant_o[1])  dc_data_o <= bus_data_i;
            if (bus_rw_o && !grant_o[1]) ic_data_o <= bus_data_i;
            dc_done_o <= grant_o[1];
            ic_done_o <= !grant_o[1];
            state     <= DONE;
          end
        end
        DONE: begin
          grant_o <= 2'b00;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Bench: round-robin/watchdog instance [0] and fixed-priority instance [1]; expected
// transactions queue up at stimulus time and are popped on done_o.
`timescale 1ns/1ps
module tb_axi_req_arbiter;

  typedef struct {
    logic         dc;
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] data;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n[2];
  logic         ic_req[2], ic_rw[2], dc_req[2], dc_rw[2];
  logic [31:0]  ic_addr[2], dc_addr[2], bus_addr[2];
  logic [127:0] ic_wd[2], dc_wd[2], ic_rd[2], dc_rd[2], bus_wd[2], bus_rd[2];
  logic         ic_done[2], dc_done[2], bus_vld[2], bus_rw[2];
  logic         rd_over[2], wr_over[2], busy[2], tmo[2];
  logic [1:0]   grant[2];

  axi_req_arbiter #(.PRIO_MODE(0), .TIMEOUT(8)) u_rr (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n[0]),
    .ic_req_i(ic_req[0]), .ic_rw_i(ic_rw[0]), .ic_addr_i(ic_addr[0]), .ic_data_i(ic_wd[0]),
    .ic_data_o(ic_rd[0]), .ic_done_o(ic_done[0]),
    .dc_req_i(dc_req[0]), .dc_rw_i(dc_rw[0]), .dc_addr_i(dc_addr[0]), .dc_data_i(dc_wd[0]),
    .dc_data_o(dc_rd[0]), .dc_done_o(dc_done[0]),
    .bus_valid_req_o(bus_vld[0]), .bus_rw_o(bus_rw[0]), .bus_addr_o(bus_addr[0]),
    .bus_data_o(bus_wd[0]), .bus_data_i(bus_rd[0]),
    .bus_rd_over_i(rd_over[0]), .bus_wr_over_i(wr_over[0]),
    .grant_o(grant[0]), .busy_o(busy[0]), .timeout_o(tmo[0]));

  axi_req_arbiter #(.PRIO_MODE(1), .TIMEOUT(0)) u_fp (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n[1]),
    .ic_req_i(ic_req[1]), .ic_rw_i(ic_rw[1]), .ic_addr_i(ic_addr[1]), .ic_data_i(ic_wd[1]),
    .ic_data_o(ic_rd[1]), .ic_done_o(ic_done[1]),
    .dc_req_i(dc_req[1]), .dc_rw_i(dc_rw[1]), .dc_addr_i(dc_addr[1]), .dc_data_i(dc_wd[1]),
    .dc_data_o(dc_rd[1]), .dc_done_o(dc_done[1]),
    .bus_valid_req_o(bus_vld[1]), .bus_rw_o(bus_rw[1]), .bus_addr_o(bus_addr[1]),
    .bus_data_o(bus_wd[1]), .bus_data_i(bus_rd[1]),
    .bus_rd_over_i(rd_over[1]), .bus_wr_over_i(wr_over[1]),
    .grant_o(grant[1]), .busy_o(busy[1]), .timeout_o(tmo[1]));

  int n_chk = 0, n_fail = 0, cyc = 0;
  txn_t exp_q[2][$];
  txn_t ic_q[2][$];
  txn_t dc_q[2][$];
  logic [127:0] mdl_ic[2], mdl_dc[2];
  int  raise_cyc[2], over_cyc[2], dly[2];
  bit  lat_chk;
  bit  hold[2], stray[2], poke[2], saw_vld[2], prev_done[2];
  bit  pend[2], pend_rw[2], stray_sent[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input int k, input bit dc, input bit rw, input logic [31:0] a,
                       input logic [127:0] d);
    txn_t t;
    t.dc = dc; t.rw = rw; t.addr = a; t.data = d;
    exp_q[k].push_back(t);
    if (dc) dc_q[k].push_back(t);
    else    ic_q[k].push_back(t);
  endtask

  // Requester + completion monitor: drops req on the edge that samples done_o.
  task automatic mon_step(input int k);
    txn_t e;
    if (!rst_n[k]) begin prev_done[k] = 1'b0; return; end
    if (prev_done[k]) chk("done_pulse", ic_done[k] | dc_done[k], 1'b0);
    prev_done[k] = ic_done[k] | dc_done[k];
    if (ic_done[k] || dc_done[k]) begin
      chk("done_onehot", ic_done[k] & dc_done[k], 1'b0);
      chk("over2done", cyc - over_cyc[k], 1);
      if (exp_q[k].size() == 0) chk("unexp_done", {ic_done[k], dc_done[k]}, 2'b00);
      else begin
        e = exp_q[k].pop_front();
        chk("done_side", dc_done[k], e.dc);
        chk("grant_done", grant[k], e.dc ? 2'b10 : 2'b01);
        if (e.rw && e.dc)  mdl_dc[k] = e.data;
        if (e.rw && !e.dc) mdl_ic[k] = e.data;
        chk("ic_data", ic_rd[k], mdl_ic[k]);
        chk("dc_data", dc_rd[k], mdl_dc[k]);
      end
      if (ic_done[k]) begin ic_req[k] = 1'b0; if (ic_q[k].size() != 0) void'(ic_q[k].pop_front()); end
      if (dc_done[k]) begin dc_req[k] = 1'b0; if (dc_q[k].size() != 0) void'(dc_q[k].pop_front()); end
    end else begin
      if (!ic_req[k] && ic_q[k].size() != 0) begin
        e = ic_q[k][0];
        ic_req[k] = 1'b1; ic_rw[k] = e.rw; ic_addr[k] = e.addr; ic_wd[k] = e.data;
        raise_cyc[k] = cyc;
      end
      if (!dc_req[k] && dc_q[k].size() != 0) begin
        e = dc_q[k][0];
        dc_req[k] = 1'b1; dc_rw[k] = e.rw; dc_addr[k] = e.addr; dc_wd[k] = e.data;
        raise_cyc[k] = cyc;
      end
    end
  endtask

  // axi_m stand-in: checks the issued request, answers after a short delay.
  task automatic resp_step(input int k);
    txn_t e;
    rd_over[k] = 1'b0;
    wr_over[k] = 1'b0;
    bus_rd[k]  = {$urandom, $urandom, $urandom, $urandom};
    if (!rst_n[k]) begin pend[k] = 1'b0; return; end
    if (bus_vld[k]) begin
      saw_vld[k] = 1'b1;
      if (exp_q[k].size() == 0) chk("unexp_req", bus_vld[k], 1'b0);
      else begin
        e = exp_q[k][0];
        chk("bus_rw", bus_rw[k], e.rw);
        chk("bus_addr", bus_addr[k], e.addr);
        if (!e.rw) chk("bus_wdata", bus_wd[k], e.data);
        chk("grant_issue", grant[k], e.dc ? 2'b10 : 2'b01);
        if (lat_chk && k == 0) chk("req2valid", cyc - raise_cyc[k], 2);
      end
      pend[k] = 1'b1; pend_rw[k] = bus_rw[k]; dly[k] = 2; stray_sent[k] = 1'b0;
    end else if (pend[k]) begin
      if (dly[k] > 0) dly[k]--;
      else if (hold[k]) begin end
      else if (stray[k] && !pend_rw[k] && !stray_sent[k]) begin
        rd_over[k] = 1'b1; stray_sent[k] = 1'b1;
      end else begin
        if (pend_rw[k]) begin
          rd_over[k] = 1'b1;
          if (exp_q[k].size() != 0) bus_rd[k] = exp_q[k][0].data;
        end else wr_over[k] = 1'b1;
        over_cyc[k] = cyc;
        pend[k] = 1'b0;
      end
    end else if (poke[k]) begin
      rd_over[k] = 1'b1; wr_over[k] = 1'b1; poke[k] = 1'b0;
    end
  endtask

  initial forever begin @(negedge clk); mon_step(0); resp_step(0); end
  initial forever begin @(negedge clk); mon_step(1); resp_step(1); end

  task automatic wait_idle(input int k, input int budget);
    int n = 0;
    while ((exp_q[k].size() != 0 || busy[k]) && n < budget) begin @(negedge clk); n++; end
    if (n >= budget) begin
      chk("bound_pending", exp_q[k].size(), 0);
      exp_q[k].delete();
    end
  endtask

  task automatic wait_vld(input int k);
    int n = 0;
    while (!saw_vld[k] && n < 50) begin @(negedge clk); n++; end
    if (!saw_vld[k]) chk("bound_vld", saw_vld[k], 1'b1);
  endtask

  task automatic chk_zero(input int k);
    chk("rst_busy", busy[k], 1'b0);
    chk("rst_grant", grant[k], 2'b00);
    chk("rst_ctl", {bus_vld[k], bus_rw[k], tmo[k], ic_done[k], dc_done[k]}, 5'b0);
    chk("rst_addr", bus_addr[k], 32'h0);
    chk("rst_bdata", bus_wd[k], 128'h0);
    chk("rst_rdata", {ic_rd[k], dc_rd[k]}, 256'h0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; ic_req[k] = 1'b0; dc_req[k] = 1'b0; ic_rw[k] = 1'b0; dc_rw[k] = 1'b0;
      ic_addr[k] = '0; dc_addr[k] = '0; ic_wd[k] = '0; dc_wd[k] = '0;
      rd_over[k] = 1'b0; wr_over[k] = 1'b0; bus_rd[k] = '0;
      mdl_ic[k] = '0; mdl_dc[k] = '0; raise_cyc[k] = 0; over_cyc[k] = 0; dly[k] = 0;
      hold[k] = 0; stray[k] = 0; poke[k] = 0; saw_vld[k] = 0; prev_done[k] = 0; pend[k] = 0;
    end
    lat_chk = 0;
    repeat (3) @(posedge clk);
    #2;
    chk_zero(0);
    chk_zero(1);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    @(posedge clk); #2;

    // Both request together from reset: DC, IC, DC, IC.
    issue(0, 1, 1, 32'h300, {4{32'h0D1D1D1D}});
    issue(0, 0, 1, 32'h400, {4{32'h1C2C2C2C}});
    issue(0, 1, 0, 32'h500, {4{32'h3E3E3E3E}});
    issue(0, 0, 1, 32'h600, {4{32'h4F4F4F4F}});
    wait_idle(0, 400);

    // Lone IC fill: 2-cycle request latency.
    lat_chk = 1;
    issue(0, 0, 1, 32'h100, 128'h44444444_33333333_22222222_11111111);
    wait_idle(0, 200);
    lat_chk = 0;

    // DC write with a stray rd_over in WAIT; dc_data_o must keep its old value.
    stray[0] = 1;
    issue(0, 1, 0, 32'h200, {4{32'hA5A5A5A5}});
    wait_idle(0, 200);
    stray[0] = 0;

    // Over pulses while idle are ignored.
    poke[0] = 1;
    repeat (4) @(negedge clk);
    chk("idle_over_busy", busy[0], 1'b0);

    // Fixed priority: DC keeps winning while IC waits.
    issue(1, 1, 1, 32'h1000, {4{32'h10001000}});
    issue(1, 1, 1, 32'h1010, {4{32'h10101010}});
    issue(1, 1, 0, 32'h1020, {4{32'h10201020}});
    issue(1, 0, 1, 32'h2000, {4{32'h20002000}});
    wait_idle(1, 400);

    // Watchdog: withhold the over pulse.
    chk("t5_tmo_pre", tmo[0], 1'b0);
    hold[0] = 1; saw_vld[0] = 0;
    issue(0, 0, 1, 32'h700, {4{32'h77777777}});
    wait_vld(0);
    repeat (4) @(negedge clk);
    chk("t5_tmo_early", tmo[0], 1'b0);
    repeat (10) @(negedge clk);
    chk("t5_tmo_set", tmo[0], 1'b1);
    hold[0] = 0;
    wait_idle(0, 200);
    chk("t5_tmo_sticky", tmo[0], 1'b1);

    // Reset in WAIT abandons the transaction.
    hold[0] = 1; saw_vld[0] = 0;
    issue(0, 1, 1, 32'h800, {4{32'h88888888}});
    wait_vld(0);
    @(posedge clk); #2;
    rst_n[0] = 1'b0;
    exp_q[0].delete(); ic_q[0].delete(); dc_q[0].delete();
    ic_req[0] = 1'b0; dc_req[0] = 1'b0; mdl_ic[0] = '0; mdl_dc[0] = '0; hold[0] = 0;
    #1;
    chk_zero(0);
    repeat (2) @(posedge clk); #2;
    rst_n[0] = 1'b1;
    @(posedge clk); #2;
    chk("t6_busy", busy[0], 1'b0);
    issue(0, 0, 1, 32'h900, {4{32'h99999999}});
    wait_idle(0, 200);
    chk("t6_tmo", tmo[0], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
